// File: rtl/risc_eunit_core.sv
// risc_eunit_core: 8x8 register file with a 13-op ALU; reads A/B by address, registers the result on rslt and writes it back to A; st (1111) writes rslt to A.
module risc_eunit_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic [2:0] opnda_addr,
  input  logic [2:0] opndb_addr,
  output logic [7:0] rslt,
  output logic [7:0] regfile0,
  output logic [7:0] regfile1,
  output logic [7:0] regfile2,
  output logic [7:0] regfile3,
  output logic [7:0] regfile4,
  output logic [7:0] regfile5,
  output logic [7:0] regfile6,
  output logic [7:0] regfile7
);
  logic [7:0] rf [8];
  logic [7:0] a, b, f;
  logic       wr;
  assign a = rf[opnda_addr];
  assign b = rf[opndb_addr];
  assign {regfile0, regfile1, regfile2, regfile3} = {rf[0], rf[1], rf[2], rf[3]};
  assign {regfile4, regfile5, regfile6, regfile7} = {rf[4], rf[5], rf[6], rf[7]};
  always_comb begin
    f  = rslt;
    wr = 1'b1;
    case (opcode)
      4'h1: f = a + b;
      4'h2: f = a - b;
      4'h3: f = a & b;
      4'h4: f = a | b;
      4'h5: f = a ^ b;
      4'h6: f = a + 8'd1;
      4'h7: f = a - 8'd1;
      4'h8: f = ~a;
      4'h9: f = ~a + 8'd1;
      4'ha: f = {1'b0, a[7:1]};
      4'hb: f = {a[6:0], 1'b0};
      4'hc: f = {a[0], a[7:1]};
      4'hd: f = {a[6:0], a[7]};
      4'hf: f = rslt;
      default: wr = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rslt  <= 8'h00;
      rf[0] <= 8'h00;
      rf[1] <= 8'h22;
      rf[2] <= 8'h44;
      rf[3] <= 8'h66;
      rf[4] <= 8'h88;
      rf[5] <= 8'haa;
      rf[6] <= 8'hcc;
      rf[7] <= 8'hff;
    end else if (wr) begin
      rslt           <= f;
      rf[opnda_addr] <= f;
    end
  end
endmodule

// File: tb/tb_risc_eunit_core.sv
// tb_risc_eunit_core: table-driven directed check of risc_eunit_core against hand-computed results.
module tb_risc_eunit_core;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic [2:0] opnda_addr = 3'd0;
  logic [2:0] opndb_addr = 3'd0;
  logic [7:0] rslt;
  logic [7:0] regfile0, regfile1, regfile2, regfile3, regfile4, regfile5, regfile6, regfile7;
  logic [7:0] rv [8];
  logic [7:0] mdl [8];
  logic [7:0] rst_vals [8];
  logic [7:0] mrs;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [3:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [7:0] r;
    logic [7:0] g;
  } vec_t;
  vec_t tv [$];
  risc_eunit_core dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .opnda_addr(opnda_addr), .opndb_addr(opndb_addr),
    .rslt(rslt), .regfile0(regfile0), .regfile1(regfile1), .regfile2(regfile2), .regfile3(regfile3),
    .regfile4(regfile4), .regfile5(regfile5), .regfile6(regfile6), .regfile7(regfile7)
  );
  always #5 clk = ~clk;
  assign rv[0] = regfile0;
  assign rv[1] = regfile1;
  assign rv[2] = regfile2;
  assign rv[3] = regfile3;
  assign rv[4] = regfile4;
  assign rv[5] = regfile5;
  assign rv[6] = regfile6;
  assign rv[7] = regfile7;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, " rslt"}, rslt, mrs);
    for (int i = 0; i < 8; i++) chk($sformatf("%s reg%0d", tag, i), rv[i], mdl[i]);
  endtask
  task automatic reset_model();
    mrs = 8'h00;
    for (int i = 0; i < 8; i++) mdl[i] = rst_vals[i];
  endtask
  task automatic apply(input string tag, input vec_t v);
    opcode = v.op;
    opnda_addr = v.a;
    opndb_addr = v.b;
    @(posedge clk);
    #1;
    mrs = v.r;
    mdl[v.a] = v.g;
    chk_all(tag);
  endtask
  initial begin
    rst_vals = '{8'h00, 8'h22, 8'h44, 8'h66, 8'h88, 8'haa, 8'hcc, 8'hff};
    tv.push_back('{4'h1, 3'd0, 3'd7, 8'hff, 8'hff});
    tv.push_back('{4'h2, 3'd1, 3'd6, 8'h56, 8'h56});
    tv.push_back('{4'h3, 3'd2, 3'd5, 8'h00, 8'h00});
    tv.push_back('{4'h4, 3'd3, 3'd4, 8'hee, 8'hee});
    tv.push_back('{4'h5, 3'd4, 3'd3, 8'h66, 8'h66});
    tv.push_back('{4'h6, 3'd5, 3'd0, 8'hab, 8'hab});
    tv.push_back('{4'h7, 3'd6, 3'd0, 8'hcb, 8'hcb});
    tv.push_back('{4'h8, 3'd7, 3'd0, 8'h00, 8'h00});
    tv.push_back('{4'h9, 3'd0, 3'd1, 8'h01, 8'h01});
    tv.push_back('{4'ha, 3'd1, 3'd2, 8'h2b, 8'h2b});
    tv.push_back('{4'hb, 3'd2, 3'd3, 8'h00, 8'h00});
    tv.push_back('{4'hc, 3'd3, 3'd4, 8'h77, 8'h77});
    tv.push_back('{4'hd, 3'd4, 3'd5, 8'hcc, 8'hcc});
    tv.push_back('{4'h0, 3'd0, 3'd1, 8'hcc, 8'h01});
    tv.push_back('{4'hf, 3'd0, 3'd5, 8'hcc, 8'hcc});
    tv.push_back('{4'h0, 3'd0, 3'd2, 8'hcc, 8'hcc});
    tv.push_back('{4'he, 3'd1, 3'd3, 8'hcc, 8'h2b});
    tv.push_back('{4'h7, 3'd7, 3'd0, 8'hff, 8'hff});
    tv.push_back('{4'h6, 3'd7, 3'd0, 8'h00, 8'h00});
    tv.push_back('{4'h6, 3'd2, 3'd0, 8'h01, 8'h01});
    tv.push_back('{4'hc, 3'd2, 3'd0, 8'h80, 8'h80});
    tv.push_back('{4'h9, 3'd2, 3'd0, 8'h80, 8'h80});
    tv.push_back('{4'h3, 3'd6, 3'd2, 8'h80, 8'h80});
    tv.push_back('{4'h1, 3'd2, 3'd6, 8'h00, 8'h00});
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    reset_model();
    chk_all("reset");
    foreach (tv[i]) apply($sformatf("v%0d", i), tv[i]);
    opcode = 4'h1;
    opnda_addr = 3'd0;
    opndb_addr = 3'd7;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    reset_model();
    chk_all("midreset");
    apply("samereg", '{4'h1, 3'd3, 3'd3, 8'hcc, 8'hcc});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
